// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator with pixel clock enable
//
// Ports:
//   clk         : pixel-domain clock
//   reset       : synchronous active-high reset
//   pix_en      : pixel enable, timing advances only when high
//   hsync/vsync : registered syncs at HS_POL/VS_POL asserted level
//   de          : registered display enable (visible region)
//   x/y         : registered pixel column/line, aligned with de and syncs
//   line_start  : one-clk pulse when the registered pixel is column 0
//   frame_start : one-clk pulse when the registered pixel is (0,0)
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = 11
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pix_en,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Boundaries pre-sized to the counter width so comparisons stay width-matched.
  localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS      = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_VIS      = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START   = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END     = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_START   = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END     = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] ZERO       = '0;
  localparam logic [CW-1:0] ONE        = CW'(1);

  logic [CW-1:0] h_q, h_d;
  logic [CW-1:0] v_q, v_d;
  logic [CW-1:0] x_q, y_q;
  logic          hsync_q, vsync_q, de_q, line_start_q, frame_start_q;

  logic h_last, v_last;
  logic hs_act, vs_act, de_act;

  always_comb begin
    h_last = (h_q == H_LAST);
    v_last = (v_q == V_LAST);
    h_d    = h_last ? ZERO : h_q + ONE;
    v_d    = v_q;
    if (h_last) begin
      v_d = v_last ? ZERO : v_q + ONE;
    end
    hs_act = (h_q >= HS_START) && (h_q < HS_END);
    vs_act = (v_q >= VS_START) && (v_q < VS_END);
    de_act = (h_q < H_VIS) && (v_q < V_VIS);
  end

  // Outputs register the current counter pixel, so they trail the counters by
  // exactly one enabled cycle. Start pulses are cleared on disabled cycles so
  // they never stretch while the raster is frozen.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_q           <= '0;
      v_q           <= '0;
      x_q           <= '0;
      y_q           <= '0;
      de_q          <= 1'b0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else if (pix_en) begin
      h_q           <= h_d;
      v_q           <= v_d;
      x_q           <= h_q;
      y_q           <= v_q;
      de_q          <= de_act;
      hsync_q       <= hs_act ? HS_POL : ~HS_POL;
      vsync_q       <= vs_act ? VS_POL : ~VS_POL;
      line_start_q  <= (h_q == ZERO);
      frame_start_q <= (h_q == ZERO) && (v_q == ZERO);
    end else begin
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen (small raster 8/2/3/1 x 4/1/2/1)
module tb_vga_timing_gen;

  logic        clk;
  logic        reset;
  logic        pix_en;
  logic        hsync, vsync, de, line_start, frame_start;
  logic [10:0] x, y;

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic        de;
    logic        hs;
    logic        vs;
    logic        ls;
    logic        fs;
  } obs_t;

  int   checks;
  int   errors;
  int   cyc;
  int   mh, mv;
  obs_t prev_e;
  obs_t exp_q[$];

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CW(11)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pix_en(pix_en),
    .hsync(hsync),
    .vsync(vsync),
    .de(de),
    .x(x),
    .y(y),
    .line_start(line_start),
    .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t sample();
    obs_t o;
    o.x  = x;
    o.y  = y;
    o.de = de;
    o.hs = hsync;
    o.vs = vsync;
    o.ls = line_start;
    o.fs = frame_start;
    return o;
  endfunction

  // Drives one clock with the given inputs and pushes the expected outputs.
  // Reference raster: H_TOTAL=14, V_TOTAL=8, hsync high x=10..12, vsync high y=5..6.
  task automatic drive(input logic en, input logic rst);
    obs_t e;
    if (rst) begin
      e = '0;
      mh = 0;
      mv = 0;
    end else if (en) begin
      e.x  = 11'(mh);
      e.y  = 11'(mv);
      e.de = (mh < 8) && (mv < 4);
      e.hs = (mh >= 10) && (mh <= 12);
      e.vs = (mv >= 5) && (mv <= 6);
      e.ls = (mh == 0);
      e.fs = (mh == 0) && (mv == 0);
      if (mh == 13) begin
        mh = 0;
        mv = (mv == 7) ? 0 : mv + 1;
      end else begin
        mh = mh + 1;
      end
    end else begin
      e    = prev_e;
      e.ls = 1'b0;
      e.fs = 1'b0;
    end
    prev_e = e;
    exp_q.push_back(e);
    pix_en = en;
    reset  = rst;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    obs_t got, e;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1);
      got = sample(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL reset_state cyc=%0d got=%h exp=%h", cyc, got, e);
      end
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0);
      got = sample(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d got=%h exp=%h", cyc, got, e);
      end
    end
  endtask

  task automatic test_free_run();
    obs_t got, e;
    int   fs_t[$];
    int   ls_last, hs_cnt, vs_cnt;
    ls_last = -1;
    hs_cnt  = 0;
    vs_cnt  = 0;
    drive(1'b0, 1'b1);
    void'(exp_q.pop_front());
    for (int i = 0; i < 230; i++) begin
      drive(1'b1, 1'b0);
      got = sample(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL free_run cyc=%0d got=%h exp=%h", cyc, got, e);
      end
      if (got.fs) fs_t.push_back(cyc);
      if (got.ls) begin
        if (ls_last >= 0) begin
          checks++;
          if (cyc - ls_last != 14) begin
            errors++;
            $display("FAIL line_period got=%0d exp=14", cyc - ls_last);
          end
        end
        ls_last = cyc;
      end
      if (fs_t.size() == 1) begin
        if (got.hs) hs_cnt++;
        if (got.vs) vs_cnt++;
      end
    end
    checks++;
    if (fs_t.size() < 3) begin
      errors++;
      $display("FAIL frame_start_count got=%0d exp=3", fs_t.size());
    end else begin
      checks++;
      if (fs_t[1] - fs_t[0] != 112 || fs_t[2] - fs_t[1] != 112) begin
        errors++;
        $display("FAIL frame_period got=%0d,%0d exp=112", fs_t[1] - fs_t[0], fs_t[2] - fs_t[1]);
      end
    end
    checks++;
    if (hs_cnt != 24) begin
      errors++;
      $display("FAIL hsync_cycles_per_frame got=%0d exp=24", hs_cnt);
    end
    checks++;
    if (vs_cnt != 28) begin
      errors++;
      $display("FAIL vsync_cycles_per_frame got=%0d exp=28", vs_cnt);
    end
  endtask

  task automatic test_half_rate();
    obs_t got, e;
    drive(1'b0, 1'b1);
    void'(exp_q.pop_front());
    for (int i = 0; i < 240; i++) begin
      drive(i[0] == 1'b0, 1'b0);
      got = sample(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL half_rate cyc=%0d got=%h exp=%h", cyc, got, e);
      end
    end
  endtask

  task automatic test_mid_reset();
    obs_t got, e;
    drive(1'b0, 1'b1);
    void'(exp_q.pop_front());
    // advance to pixel (5,2): 2 lines of 14 plus 5 pixels
    for (int i = 0; i < 34; i++) begin
      drive(1'b1, 1'b0);
      got = sample(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL mid_run cyc=%0d got=%h exp=%h", cyc, got, e);
      end
    end
    checks++;
    if (got.x !== 11'd5 || got.y !== 11'd2) begin
      errors++;
      $display("FAIL mid_position got=(%0d,%0d) exp=(5,2)", got.x, got.y);
    end
    drive(1'b1, 1'b1);
    got = sample(); e = exp_q.pop_front(); checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL mid_reset_values got=%h exp=%h", got, e);
    end
    drive(1'b1, 1'b0);
    got = sample(); e = exp_q.pop_front(); checks++;
    if (got !== e || got.fs !== 1'b1 || got.x !== 11'd0 || got.y !== 11'd0) begin
      errors++;
      $display("FAIL restart_pixel got=%h exp=%h", got, e);
    end
  endtask

  task automatic test_random_enable();
    obs_t got, e;
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), ($urandom_range(0, 99) == 0));
      got = sample(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL random_enable cyc=%0d got=%h exp=%h", cyc, got, e);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    mh     = 0;
    mv     = 0;
    prev_e = '0;
    reset  = 1'b1;
    pix_en = 1'b0;
    test_reset();
    test_free_run();
    test_half_rate();
    test_mid_reset();
    test_random_enable();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
